// File: rtl/vga_pixel_sink.sv
// Pixel sink: 3-bit framebuffer written by (x,y,color) requests, scanned out as 640x480 VGA with 4x4 replication.
// Latency: write_ack one clk after a stored request; video one tick behind counters. No backpressure: requests dropped while busy or off-screen.
module vga_pixel_sink #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] x,
  input  logic [8:0] y,
  input  logic [2:0] color,
  input  logic       write,
  output logic       write_ack,
  output logic       busy,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_clk
);

  localparam int              NPIX      = FB_W * FB_H;
  localparam int              AW        = $clog2(NPIX);
  localparam logic [31:0]     W32       = 32'(FB_W);
  localparam logic [31:0]     H32       = 32'(FB_H);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_addr;
  logic            req_ok;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [2:0]      wdata;
  logic [AW-1:0]   raddr;
  logic [2:0]      rdata;
  logic [2:0]      mem [NPIX];

  logic            tgl;
  logic [9:0]      hc, vc;
  logic            hs_raw, vs_raw, vis;

  assign req_ok = write && (32'(x) < W32) && (32'(y) < H32);

  // Clear sweep owns the write port until the last address is zeroed.
  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    waddr     = clr_addr;
    wdata     = 3'b000;
    busy      = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        we   = 1'b1;
        if (clr_addr == LAST_ADDR) state_nxt = RUN;
      end
      RUN: begin
        we    = req_ok;
        waddr = AW'(32'(y) * W32 + 32'(x));
        wdata = color;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      write_ack <= 1'b0;
    end else begin
      state     <= state_nxt;
      write_ack <= (state == RUN) && req_ok;
      if (state == CLEAR)
        clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + AW'(1);
    end
  end

  // Read-before-write: a same-address read in the write cycle sees old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgl <= 1'b0;
      hc  <= '0;
      vc  <= '0;
    end else begin
      tgl <= ~tgl;
      if (tgl) begin
        if (hc == 10'd799) begin
          hc <= '0;
          vc <= (vc == 10'd524) ? '0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  assign vga_clk = tgl;
  assign hs_raw  = !((hc >= 10'd656) && (hc <= 10'd751));
  assign vs_raw  = !((vc >= 10'd490) && (vc <= 10'd491));
  assign vis     = (hc < 10'd640) && (vc < 10'd480);

  // Off-screen counters would index past the buffer, so park the read at 0.
  always_comb begin
    raddr = '0;
    if (vis) raddr = AW'(32'(vc[9:2]) * W32 + 32'(hc[9:2]));
  end

  // RAM data for the current hc/vc lands on the non-tick edge; register it with matching syncs on the tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else if (tgl) begin
      vga_hs      <= hs_raw;
      vga_vs      <= vs_raw;
      vga_blank_n <= vis;
      vga_r       <= (vis && rdata[2]) ? 8'hFF : 8'h00;
      vga_g       <= (vis && rdata[1]) ? 8'hFF : 8'h00;
      vga_b       <= (vis && rdata[0]) ? 8'hFF : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink: random requests against a pixel-time reference model.
module tb_vga_pixel_sink;
  localparam int W  = 160;
  localparam int H  = 120;
  localparam int NP = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] x, y;
  logic [2:0] color;
  logic       write;
  logic       write_ack, busy, vga_hs, vga_vs, vga_blank_n, vga_clk;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_pixel_sink #(.FB_W(W), .FB_H(H)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .color(color), .write(write),
    .write_ack(write_ack), .busy(busy), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_clk(vga_clk)
  );

  always #10 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  int       n;          // clk edges since reset release
  bit       ack_e;
  bit       rgb_chk;    // model knows the framebuffer contents
  bit [2:0] fb_m [NP];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk_eq("rst_busy", busy, 1);
    chk_eq("rst_ack", write_ack, 0);
    chk_eq("rst_hs", vga_hs, 1);
    chk_eq("rst_vs", vga_vs, 1);
    chk_eq("rst_blank", vga_blank_n, 0);
    chk_eq("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk_eq("rst_vclk", vga_clk, 0);
  endtask

  function automatic logic [23:0] expand(input bit [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  // Each output tick shows the pixel at the previous tick's scan position.
  task automatic check_outs();
    int k, q, h, v;
    bit hs_e, vs_e, bl_e;
    logic [23:0] rgb_e;
    chk_eq("busy", busy, (n < NP) ? 1 : 0);
    chk_eq("write_ack", write_ack, ack_e);
    chk_eq("vga_clk", vga_clk, n % 2);
    k = n / 2;
    if (k == 0) begin
      hs_e = 1; vs_e = 1; bl_e = 0; rgb_e = '0;
    end else begin
      q    = k - 1;
      h    = q % 800;
      v    = (q / 800) % 525;
      hs_e = !(h >= 656 && h <= 751);
      vs_e = !(v >= 490 && v <= 491);
      bl_e = (h < 640) && (v < 480);
      rgb_e = bl_e ? expand(fb_m[(v / 4) * W + h / 4]) : 24'h0;
    end
    chk_eq("hsync", vga_hs, hs_e);
    chk_eq("vsync", vga_vs, vs_e);
    chk_eq("blank_n", vga_blank_n, bl_e);
    if (!bl_e || rgb_chk) chk_eq("rgb", {vga_r, vga_g, vga_b}, rgb_e);
  endtask

  task automatic step();
    @(posedge clk);
    if (n >= NP && write && x < W && y < H) begin
      ack_e = 1;
      fb_m[int'(y) * W + int'(x)] = color;
    end else begin
      ack_e = 0;
    end
    n++;
    @(negedge clk);
    check_outs();
  endtask

  task automatic put(input bit w, input int xx, input int yy, input int c);
    write = w;
    x     = 9'(xx);
    y     = 9'(yy);
    color = 3'(c);
    step();
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; x = '0; y = '0; color = '0;
    n = 0; ack_e = 0; rgb_chk = 0;
    foreach (fb_m[i]) fb_m[i] = 3'b000;

    #2 reset = 1'b1;
    #1 chk_reset_vals();
    repeat (3) begin @(negedge clk); chk_reset_vals(); end
    reset = 1'b0; n = 0; ack_e = 0;

    // Writes held during the clear must be ignored.
    write = 1'b1; color = 3'b111; y = '0;
    for (int i = 0; i < 9000; i++) begin x = 9'(i % 4); step(); end

    reset = 1'b1;
    #1 chk_reset_vals();
    repeat (2) begin @(negedge clk); chk_reset_vals(); end
    reset = 1'b0; n = 0; ack_e = 0;
    rgb_chk = 1;   // rows scanned during this clear were zeroed by the aborted sweep
    for (int i = 0; i < NP; i++) begin x = 9'(i % 4); step(); end

    rgb_chk = 0;
    put(1, 5, 3, 3'b101);
    put(0, 0, 0, 0);
    put(1, 160, 0, 3'b111);
    put(1, 0, 120, 3'b111);
    put(1, 159, 119, 3'b010);
    put(1, 511, 511, 3'b111);
    put(1, 0, 0, 3'b110);
    for (int i = 0; i < 200; i++) begin
      write = ($urandom % 4) != 0;
      x     = 9'($urandom_range(0, 175));
      y     = 9'($urandom_range(4, 130));
      color = 3'($urandom);
      step();
    end
    write = 1'b0;
    repeat (4) step();
    rgb_chk = 1;
    while (n < NP + 2 * 800 * 20) step();

    // Request in flight when reset hits must vanish without an ack.
    write = 1'b1; x = 9'd7; y = 9'd3; color = 3'b010;
    reset = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk); chk_reset_vals();
    reset = 1'b0; n = 0; ack_e = 0; write = 1'b0; rgb_chk = 0;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_pixel_sink.md
VGA_PIXEL_SINK -- requirements
Module: vga_pixel_sink

Interface
REQ-001 Parameter FB_W, default 160, framebuffer width in pixels.
REQ-002 Parameter FB_H, default 120, framebuffer height in pixels.
REQ-003 clk  input  1  system clock, 50 MHz; the block's only clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 x  input  9  pixel column of a write request.
REQ-006 y  input  9  pixel row of a write request.
REQ-007 color  input  3  pixel colour, bits {R,G,B}.
REQ-008 write  input  1  write strobe; one request per cycle while high.
REQ-009 write_ack  output  1  one-cycle pulse: request from previous cycle stored.
REQ-010 busy  output  1  high while the post-reset clear runs.
REQ-011 vga_r, vga_g, vga_b  output  8 each  colour channels.
REQ-012 vga_hs, vga_vs  output  1 each  sync outputs, active-low.
REQ-013 vga_blank_n  output  1  high during the visible region only.
REQ-014 vga_clk  output  1  pixel clock, 25 MHz, clk divided by 2.

Function
REQ-015 Internal dual-port framebuffer SHALL be FB_W*FB_H x 3 bits: one write port, one read port, synchronous read, 1-cycle latency.
REQ-016 Address SHALL be y*FB_W + x.
REQ-017 FSM SHALL have two states, CLEAR and RUN; CLEAR is entered on reset.
REQ-018 In CLEAR, the block SHALL write 3'b000 to address 0..FB_W*FB_H-1, one per clk, with busy=1.
REQ-019 The block SHALL move from CLEAR to RUN on the cycle after address FB_W*FB_H-1 is written; busy SHALL fall in the same cycle.
REQ-020 In CLEAR, write requests SHALL be dropped with no write_ack.
REQ-021 In RUN, a request with write=1, x<FB_W and y<FB_H SHALL be stored at the clock edge; write_ack=1 SHALL follow for exactly the next cycle.
REQ-022 In RUN, a request with x>=FB_W or y>=FB_H SHALL be dropped: no write, no write_ack.
REQ-023 Back-to-back requests SHALL be accepted every cycle, producing back-to-back write_ack.
REQ-024 A toggle register SHALL produce a pixel-enable tick every second clk; vga_clk SHALL equal the toggle register.
REQ-025 The horizontal counter hc SHALL count 0..799 on ticks, then wrap to 0.
REQ-026 The vertical counter vc SHALL increment when hc wraps and SHALL itself wrap 524 -> 0.
REQ-027 Scan-out SHALL run in both CLEAR and RUN.
REQ-028 The horizontal sync raw signal SHALL be low for 656 <= hc <= 751.
REQ-029 The vertical sync raw signal SHALL be low for 490 <= vc <= 491.
REQ-030 The visible region SHALL be hc<640 and vc<480.
REQ-031 Read address SHALL be (vc>>2)*FB_W + (hc>>2), i.e. 4x4 pixel replication.
REQ-032 vga_hs, vga_vs and vga_blank_n SHALL be delayed by one tick, so all VGA outputs update on ticks and match the RAM read latency.
REQ-033 Each channel SHALL be 8'hFF if its colour bit is 1, otherwise 8'h00.
REQ-034 All channels SHALL be 0 when blanked.
REQ-035 A same-address write and read in one cycle SHALL return old data.

Reset
REQ-036 While reset=1, outputs SHALL be: write_ack=0, busy=1, vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, vga_clk=0.
REQ-037 While reset=1, hc, vc, the toggle register and the clear address SHALL be 0.
REQ-038 Reset asserted mid-operation (CLEAR or RUN) SHALL abort immediately and restart CLEAR from address 0.
REQ-039 A write in flight at reset SHALL be lost, and no write_ack SHALL be issued for it.

Verification
REQ-040 Reset release -> busy=1 for exactly 19200 cycles, then 0; a read of any address returns 000.
REQ-041 RUN, write x=5 y=3 color=3'b101 -> write_ack next cycle only.
REQ-042 Scan-out at vc=12..15, hc=20..23 -> r=FF, g=00, b=FF with blank_n=1.
REQ-043 RUN, write x=160 y=0, then x=0 y=120 -> no write_ack; framebuffer unchanged.
REQ-044 Free run one frame -> hsync low pulse of 96 ticks, line period 800 ticks, vsync low for 2 lines, frame period 525 lines; blank_n high 640 ticks per visible line.
REQ-045 write held high with color=3'b111 at x=0..3 y=0 during CLEAR -> no write_ack; readback 000.
REQ-046 Reset pulse at CLEAR address 9000 -> clear restarts, busy lasts a full 19200 cycles after release.
